// File: rtl/game_fsm.sv
// Game-flow controller for a flappy-bird style game: title / play / game-over
// sequencing, button press detection, packed-BCD scoring and prompt blinking.
module game_fsm #(
    parameter int GO_HOLD_FRAMES = 60,
    parameter int BLINK_FRAMES   = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        frame_tick,
    input  logic        collision,
    input  logic        pipe_passed,
    output logic [1:0]  state,
    output logic        flap,
    output logic        play_rst,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        blink
);

    localparam int HW = (GO_HOLD_FRAMES < 1) ? 1 : $clog2(GO_HOLD_FRAMES + 1);
    localparam int BW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(GO_HOLD_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        TITLE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2,
        ILLEGAL   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            flap_reg, flap_next;
    logic            play_rst_reg, play_rst_next;
    logic [15:0]     score_reg, score_next;
    logic [15:0]     high_score_reg, high_score_next;
    logic            blink_reg, blink_next;
    logic [BW-1:0]   blink_cnt_reg, blink_cnt_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;

    logic            s1_reg, s2_reg, p_reg;
    logic            s1_valid_reg, s2_valid_reg, armed_reg;
    logic            rise;

    // A press only counts once the synchronizer has seen the button low after
    // reset, so a button already held at reset release cannot start a game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            p_reg        <= 1'b0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            armed_reg    <= 1'b0;
        end else begin
            s1_reg       <= btn;
            s2_reg       <= s1_reg;
            p_reg        <= s2_reg;
            s1_valid_reg <= 1'b1;
            s2_valid_reg <= s1_valid_reg;
            armed_reg    <= armed_reg | (s2_valid_reg & ~s2_reg);
        end
    end

    assign rise = s2_reg & ~p_reg & armed_reg;

    logic [3:0]  digit_nine;
    logic [15:0] score_inc_raw;
    logic [15:0] score_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bcd
            logic [3:0] digit;
            logic       carry_in;
            assign digit          = score_reg[gi*4 +: 4];
            assign digit_nine[gi] = (digit == 4'd9);
            if (gi == 0) begin : g_lsd
                assign carry_in = 1'b1;
            end else begin : g_upper
                assign carry_in = &digit_nine[gi-1:0];
            end
            assign score_inc_raw[gi*4 +: 4] = !carry_in       ? digit :
                                              digit_nine[gi] ? 4'd0  : digit + 4'd1;
        end
    endgenerate

    // 9999 plus one stays at 9999
    assign score_inc = (&digit_nine) ? score_reg : score_inc_raw;

    logic            blink_wrap;
    logic [BW-1:0]   blink_cnt_step;

    assign blink_wrap     = (blink_cnt_reg == BLINK_LAST);
    assign blink_cnt_step = blink_wrap ? '0 : blink_cnt_reg + BW'(1);

    always_comb begin
        state_next      = state_reg;
        flap_next       = 1'b0;
        play_rst_next   = 1'b0;
        score_next      = score_reg;
        high_score_next = high_score_reg;
        blink_next      = blink_reg;
        blink_cnt_next  = blink_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;

        case (state_reg)
            TITLE: begin
                if (rise) begin
                    state_next     = PLAY;
                    play_rst_next  = 1'b1;
                    score_next     = 16'h0000;
                    blink_next     = 1'b0;
                    blink_cnt_next = '0;
                end else if (frame_tick) begin
                    blink_next     = blink_reg ^ blink_wrap;
                    blink_cnt_next = blink_cnt_step;
                end
            end

            PLAY: begin
                blink_next     = 1'b0;
                blink_cnt_next = '0;
                if (collision) begin
                    // Crash wins over any press or pipe credit in the same cycle
                    state_next    = GAME_OVER;
                    hold_cnt_next = '0;
                    blink_next    = 1'b1;
                    if (score_reg > high_score_reg) begin
                        high_score_next = score_reg;
                    end
                end else begin
                    if (rise) begin
                        flap_next = 1'b1;
                    end
                    if (pipe_passed) begin
                        score_next = score_inc;
                    end
                end
            end

            GAME_OVER: begin
                if (rise && (hold_cnt_reg == HOLD_MAX)) begin
                    state_next     = TITLE;
                    blink_next     = 1'b1;
                    blink_cnt_next = '0;
                end else if (frame_tick) begin
                    if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
                    blink_next     = blink_reg ^ blink_wrap;
                    blink_cnt_next = blink_cnt_step;
                end
            end

            default: begin
                state_next = TITLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= TITLE;
            flap_reg       <= 1'b0;
            play_rst_reg   <= 1'b0;
            score_reg      <= 16'h0000;
            high_score_reg <= 16'h0000;
            blink_reg      <= 1'b1;
            blink_cnt_reg  <= '0;
            hold_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            flap_reg       <= flap_next;
            play_rst_reg   <= play_rst_next;
            score_reg      <= score_next;
            high_score_reg <= high_score_next;
            blink_reg      <= blink_next;
            blink_cnt_reg  <= blink_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    assign state      = state_reg;
    assign flap       = flap_reg;
    assign play_rst   = play_rst_reg;
    assign score      = score_reg;
    assign high_score = high_score_reg;
    assign blink      = blink_reg;

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter GO_HOLD_FRAMES, default 60: frame_tick count in GAME_OVER before a restart press is accepted.
REQ-002 Parameter BLINK_FRAMES, default 30: frame_tick count between blink toggles.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 btn  in  1  raw player push-button, asynchronous to clk, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse once per video frame.
REQ-007 collision  in  1  level, high while bird overlaps pipe/ground.
REQ-008 pipe_passed  in  1  one-cycle pulse when bird clears a pipe.
REQ-009 state  out  2  game state: 0 TITLE, 1 PLAY, 2 GAME_OVER; drives the title-logo overlay (logo visible only when state==0).
REQ-010 flap  out  1  one-cycle pulse, bird impulse request.
REQ-011 play_rst  out  1  one-cycle pulse, re-initialise bird/pipe logic.
REQ-012 score  out  16  4-digit packed BCD current score.
REQ-013 high_score  out  16  4-digit packed BCD best score.
REQ-014 blink  out  1  "press button" prompt enable.

Function
REQ-015 btn SHALL pass a 2-flop synchronizer (s1, s2) plus a history flop p; press event rise = s2 & ~p.
REQ-016 btn low->high sampled at edge k SHALL give rise high for the cycle after edge k+1; state/flap/play_rst respond at edge k+2.
REQ-017 Holding btn SHALL produce exactly one rise; no re-trigger until btn is released and pressed again.
REQ-018 TITLE: rise SHALL go to PLAY, pulse play_rst for one cycle, clear score to 0000, no flap.
REQ-019 PLAY: rise SHALL pulse flap for one cycle (registered, same edge as the state response in REQ-016).
REQ-020 PLAY: pipe_passed SHALL increment score by 1 in BCD with per-digit carry (0009->0010, 0099->0100); 9999 saturates.
REQ-021 PLAY: collision high at an edge SHALL go to GAME_OVER at that edge; same-cycle rise and pipe_passed are ignored (no flap, no increment).
REQ-022 On the edge entering GAME_OVER, high_score SHALL load score if score > high_score (unsigned compare of packed BCD), else hold.
REQ-023 GAME_OVER: hold counter SHALL clear on entry and count frame_ticks, saturating at GO_HOLD_FRAMES; rise before saturation is ignored.
REQ-024 GAME_OVER with counter == GO_HOLD_FRAMES: rise SHALL go to TITLE; score holds its value until next TITLE->PLAY.
REQ-025 state encoding 3 SHALL go to TITLE on next edge, no other side effects.
REQ-026 blink SHALL be 0 in PLAY; SHALL load 1 on entry to TITLE or GAME_OVER and toggle after every BLINK_FRAMES frame_ticks there.
REQ-027 frame_tick and rise in the same cycle SHALL both take effect.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-029 high_score SHALL be modified only by REQ-022 and reset.

Reset
REQ-030 rst_n low SHALL immediately force: state 0, flap 0, play_rst 0, score 0000, high_score 0000, blink 1, hold counter 0, s1/s2/p 0.
REQ-031 Reset mid-game SHALL discard score and high_score; first rise after release behaves per REQ-018.
REQ-032 Release of rst_n with btn already high SHALL NOT produce a rise until btn is released and re-pressed.

Verification
REQ-033 Reset, btn press held 10 cycles -> state 0->1 exactly once, play_rst one cycle at edge k+2, flap 0, score 0000.
REQ-034 PLAY, 12 pipe_passed pulses, then 3 presses -> score 0012, exactly 3 one-cycle flap pulses, each 2 edges after its press.
REQ-035 PLAY, score 0012, collision and pipe_passed same cycle -> state 2, score 0012, high_score 0012; second game ending at 0005 -> high_score stays 0012.
REQ-036 GAME_OVER, GO_HOLD_FRAMES=4: press after 3 frame_ticks -> stays 2; press after 4th -> state 0, score still 0012.
REQ-037 Preload score 9999 via 9999 pipe_passed pulses (or 0099 with one more) -> 9999 saturates; 0099+1 -> 0100.
REQ-038 Assert rst_n low mid-PLAY with btn high -> all outputs per REQ-030 same cycle; after release, no state change until btn re-pressed.
